// File: rtl/spawn_timer_pkg.sv
// spawn_timer_pkg
//   Shared constants and helpers for the spawn timer:
//   - shrink-mode encodings applied on level-up
//   - seed and tap mask of the 8-bit lane-select LFSR
//   - lane_w(): index width needed to address a number of lanes
package spawn_timer_pkg;

  localparam int unsigned MODE_HALVE = 0;  // period >>= 1 on level-up
  localparam int unsigned MODE_SUB   = 1;  // period -= STEP on level-up (no wrap)

  // x^8 + x^6 + x^5 + x^4 + 1 -> state bits 7,5,4,3 feed the XOR.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Smallest w with 2**w >= lanes; lanes is restricted to 2..16.
  function automatic int lane_w(input int lanes);
    int w;
    w = 0;
    for (int i = 0; i < 5; i++) begin
      if ((1 << i) < lanes) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8
//   8-bit Fibonacci LFSR, shifting left with feedback into bit 0.
//   Advances only when step is high; the non-zero seed keeps it out of
//   the all-zero lock-up state.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset (loads LFSR_SEED)
//   step - advance one position this cycle
//   q    - current LFSR state
module lfsr8
  import spawn_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [7:0] q
);

  logic feedback;
  assign feedback = ^(q & LFSR_TAPS);

  // NOTE: sequential state is always written with non-blocking (<=)
  // assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)       q <= LFSR_SEED;
    else if (step) q <= {q[6:0], feedback};
  end

endmodule

// File: rtl/spawn_timer.sv
// spawn_timer
//   Obstacle/event generation timer. Counts enabled cycles and emits a
//   one-cycle spawn pulse every period+1 enabled cycles, with a
//   pseudo-random lane picked from an LFSR. Each rising edge of levelup
//   raises the level (saturating at MAX_LEVEL) and shrinks the period,
//   either by halving or by subtracting STEP, never below MIN_PERIOD.
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   en         - run enable; low freezes the counter and blocks spawns
//   levelup    - level-up request, rising edge counts once
//   spawn      - one-cycle pulse per elapsed interval
//   spawn_lane - lane for the current spawn, valid while spawn is high
//   period     - current interval setting (cycles-1 between spawns)
//   level      - current level
//   at_floor   - period has reached MIN_PERIOD
module spawn_timer
  import spawn_timer_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] INIT_PERIOD = 32'h00030D3F,
  parameter logic [WIDTH-1:0] MIN_PERIOD  = 32'h00001000,
  parameter int unsigned      MODE        = MODE_HALVE,
  parameter logic [WIDTH-1:0] STEP        = 32'h00004000,
  parameter int unsigned      MAX_LEVEL   = 15,
  parameter int unsigned      LVW         = 4,
  parameter int unsigned      LANES       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      levelup,
  output logic                      spawn,
  output logic [lane_w(LANES)-1:0]  spawn_lane,
  output logic [WIDTH-1:0]          period,
  output logic [LVW-1:0]            level,
  output logic                      at_floor
);

  localparam int LW = lane_w(LANES);

  logic [WIDTH-1:0] count;
  logic             lv_q;
  logic             lv_edge;
  logic             fire;
  logic [WIDTH-1:0] raw_period;
  logic [WIDTH-1:0] next_period;
  logic [7:0]       lfsr_q;
  logic             unused_lfsr;

  // >= rather than == so a period cut below the running count fires on
  // the next enabled edge instead of waiting for a full counter wrap.
  assign fire     = en && (count >= period);
  assign lv_edge  = levelup & ~lv_q;
  assign at_floor = (period == MIN_PERIOD);

  // Only the low lane bits are consumed; the rest of the state is just
  // the generator's memory.
  assign unused_lfsr = ^lfsr_q;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (fire),
    .q    (lfsr_q)
  );

  // Shrunk period for a level-up, clamped to the floor.
  // NOTE: every signal driven in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    raw_period = period >> 1;
    if (MODE == MODE_SUB) begin
      // Explicit compare avoids unsigned wraparound below STEP.
      raw_period = (period > STEP) ? (period - STEP) : '0;
    end
    next_period = (raw_period < MIN_PERIOD) ? MIN_PERIOD : raw_period;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      spawn      <= 1'b0;
      spawn_lane <= '0;
      period     <= INIT_PERIOD;
      level      <= '0;
      lv_q       <= 1'b0;
    end else begin
      // Edge history tracks levelup even while paused.
      lv_q <= levelup;

      if (fire) begin
        count      <= '0;
        spawn      <= 1'b1;
        spawn_lane <= lfsr_q[LW-1:0];
      end else begin
        if (en) count <= count + 1'b1;
        spawn <= 1'b0;
      end

      // Level-up never touches the counter; on a coincident expiry the
      // spawn above used the old period and the new one applies next.
      if (lv_edge && (level < LVW'(MAX_LEVEL))) begin
        level  <= level + 1'b1;
        period <= next_period;
      end
    end
  end

endmodule

// File: tb/tb_spawn_timer.sv
// tb_spawn_timer
//   Directed bench for spawn_timer with WIDTH=8, INIT_PERIOD=15,
//   MIN_PERIOD=3, MAX_LEVEL=3, LANES=4. dut0 uses the halving rule,
//   dut1 the subtract rule with STEP=5; both share stimulus.
module tb_spawn_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       levelup = 1'b0;

  logic       spawn0, spawn1;
  logic [1:0] lane0, lane1;
  logic [7:0] period0, period1;
  logic [3:0] level0, level1;
  logic       floor0, floor1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  spawn_timer #(
    .WIDTH(8), .INIT_PERIOD(8'd15), .MIN_PERIOD(8'd3), .MODE(0),
    .STEP(8'd5), .MAX_LEVEL(3), .LVW(4), .LANES(4)
  ) dut0 (
    .clk(clk), .rst(rst), .en(en), .levelup(levelup),
    .spawn(spawn0), .spawn_lane(lane0), .period(period0),
    .level(level0), .at_floor(floor0)
  );

  spawn_timer #(
    .WIDTH(8), .INIT_PERIOD(8'd15), .MIN_PERIOD(8'd3), .MODE(1),
    .STEP(8'd5), .MAX_LEVEL(3), .LVW(4), .LANES(4)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en), .levelup(levelup),
    .spawn(spawn1), .spawn_lane(lane1), .period(period1),
    .level(level1), .at_floor(floor1)
  );

  // Inputs change and outputs are read 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic run);
    rst = 1'b1; en = run; levelup = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; levelup = 1'b1;
    tick(); tick();
    total++; if (spawn0 !== 1'b0) $display("FAIL reset_spawn got %0b want 0", spawn0); else passed++;
    total++; if (lane0 !== 2'd0) $display("FAIL reset_lane got %0d want 0", lane0); else passed++;
    total++; if (period0 !== 8'd15) $display("FAIL reset_period got %0d want 15", period0); else passed++;
    total++; if (level0 !== 4'd0) $display("FAIL reset_level got %0d want 0", level0); else passed++;
    total++; if (floor0 !== 1'b0) $display("FAIL reset_at_floor got %0b want 0", floor0); else passed++;
    rst = 1'b0; levelup = 1'b0;
  endtask

  // Expected lanes: low two bits of A5, 4A, 95, 2A, 54.
  task automatic test_spawn_spacing();
    logic [1:0] lanes_exp [5] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd0};
    apply_reset(1'b1);
    en = 1'b1;
    for (int s = 0; s < 5; s++) begin
      for (int i = 1; i <= 16; i++) begin
        tick();
        total++;
        if (spawn0 !== (i == 16))
          $display("FAIL spacing_spawn s=%0d i=%0d got %0b want %0b", s, i, spawn0, (i == 16));
        else passed++;
        if (i == 16) begin
          total++;
          if (lane0 !== lanes_exp[s]) $display("FAIL spawn_lane s=%0d got %0d want %0d", s, lane0, lanes_exp[s]);
          else passed++;
        end
      end
    end
    total++; if (level0 !== 4'd0) $display("FAIL spacing_level got %0d want 0", level0); else passed++;
  endtask

  // Paused throughout, which also shows edges are seen with en low.
  task automatic test_mode0_levelup();
    logic [7:0] per_exp [4] = '{8'd7, 8'd3, 8'd3, 8'd3};
    logic [3:0] lvl_exp [4] = '{4'd1, 4'd2, 4'd3, 4'd3};
    logic       flr_exp [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    apply_reset(1'b0);
    for (int p = 0; p < 4; p++) begin
      levelup = 1'b1; tick();
      levelup = 1'b0; tick(); tick();
      total++; if (period0 !== per_exp[p]) $display("FAIL m0_period p=%0d got %0d want %0d", p, period0, per_exp[p]); else passed++;
      total++; if (level0 !== lvl_exp[p]) $display("FAIL m0_level p=%0d got %0d want %0d", p, level0, lvl_exp[p]); else passed++;
      total++; if (floor0 !== flr_exp[p]) $display("FAIL m0_at_floor p=%0d got %0b want %0b", p, floor0, flr_exp[p]); else passed++;
    end
  endtask

  task automatic test_mode1_levelup();
    logic [7:0] per_exp [3] = '{8'd5, 8'd3, 8'd3};
    logic [3:0] lvl_exp [3] = '{4'd2, 4'd3, 4'd3};
    apply_reset(1'b0);
    levelup = 1'b1;
    tick();
    total++; if (period1 !== 8'd10) $display("FAIL m1_first_period got %0d want 10", period1); else passed++;
    for (int i = 1; i < 20; i++) tick();
    total++; if (period1 !== 8'd10) $display("FAIL m1_held_period got %0d want 10", period1); else passed++;
    total++; if (level1 !== 4'd1) $display("FAIL m1_held_level got %0d want 1", level1); else passed++;
    levelup = 1'b0; tick();
    for (int p = 0; p < 3; p++) begin
      levelup = 1'b1; tick();
      levelup = 1'b0; tick();
      total++; if (period1 !== per_exp[p]) $display("FAIL m1_period p=%0d got %0d want %0d", p, period1, per_exp[p]); else passed++;
      total++; if (level1 !== lvl_exp[p]) $display("FAIL m1_level p=%0d got %0d want %0d", p, level1, lvl_exp[p]); else passed++;
    end
    total++; if (floor1 !== 1'b1) $display("FAIL m1_at_floor got %0b want 1", floor1); else passed++;
  endtask

  // Counter at 12 when period drops to 7: fires one edge later.
  task automatic test_levelup_mid_count();
    apply_reset(1'b1);
    en = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    levelup = 1'b1; tick();
    total++; if (spawn0 !== 1'b0) $display("FAIL cut_spawn_early got %0b want 0", spawn0); else passed++;
    total++; if (period0 !== 8'd7) $display("FAIL cut_period got %0d want 7", period0); else passed++;
    levelup = 1'b0; tick();
    total++; if (spawn0 !== 1'b1) $display("FAIL cut_spawn got %0b want 1", spawn0); else passed++;
    for (int s = 0; s < 2; s++) begin
      for (int i = 1; i <= 8; i++) begin
        tick();
        total++;
        if (spawn0 !== (i == 8)) $display("FAIL cut_spacing s=%0d i=%0d got %0b want %0b", s, i, spawn0, (i == 8));
        else passed++;
      end
    end
  endtask

  task automatic test_pause();
    apply_reset(1'b1);
    en = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (spawn0 !== 1'b0) $display("FAIL pause_spawn i=%0d got %0b want 0", i, spawn0); else passed++;
    end
    en = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      total++;
      if (spawn0 !== (i == 7)) $display("FAIL resume_spawn i=%0d got %0b want %0b", i, spawn0, (i == 7));
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(1'b0);
    for (int p = 0; p < 2; p++) begin
      levelup = 1'b1; tick();
      levelup = 1'b0; tick();
    end
    total++; if (level0 !== 4'd2) $display("FAIL mid_setup_level got %0d want 2", level0); else passed++;
    en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    levelup = 1'b1; rst = 1'b1;
    tick();
    total++; if (period0 !== 8'd15) $display("FAIL mid_rst_period got %0d want 15", period0); else passed++;
    total++; if (level0 !== 4'd0) $display("FAIL mid_rst_level got %0d want 0", level0); else passed++;
    total++; if (spawn0 !== 1'b0) $display("FAIL mid_rst_spawn got %0b want 0", spawn0); else passed++;
    total++; if (lane0 !== 2'd0) $display("FAIL mid_rst_lane got %0d want 0", lane0); else passed++;
    total++; if (floor0 !== 1'b0) $display("FAIL mid_rst_at_floor got %0b want 0", floor0); else passed++;
    rst = 1'b0;
    tick();
    total++; if (period0 !== 8'd7) $display("FAIL post_rst_period got %0d want 7", period0); else passed++;
    total++; if (level0 !== 4'd1) $display("FAIL post_rst_level got %0d want 1", level0); else passed++;
    levelup = 1'b0;
  endtask

  initial begin
    test_reset();
    test_spawn_spacing();
    test_mode0_levelup();
    test_mode1_levelup();
    test_levelup_mid_count();
    test_pause();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
